// File: rtl/rtc_pkg.sv
// ============================================================================
// rtc_pkg : shared BCD types, limits and helpers for the time-of-day counter
// Revision: 1.0
// ============================================================================
`default_nettype none

package rtc_pkg;

  typedef struct packed {
    logic [2:0] tens;
    logic [3:0] units;
  } bcd_pair_t;

  typedef struct packed {
    bcd_pair_t val;
    logic      carry;
  } bcd_inc_t;

  localparam logic [2:0] SEC_MAX_TENS = 3'd5;
  localparam logic [3:0] UNITS_MAX    = 4'd9;
  localparam logic [7:0] HR_MAX       = 8'h23;

  function automatic bcd_inc_t bcd_pair_inc(input bcd_pair_t v, input logic [2:0] max_tens);
    bcd_inc_t r;
    r.val   = v;
    r.carry = 1'b0;
    if (v.units == UNITS_MAX) begin
      r.val.units = 4'd0;
      if (v.tens == max_tens) begin
        r.val.tens = 3'd0;
        r.carry    = 1'b1;
      end else begin
        r.val.tens = v.tens + 3'd1;
      end
    end else begin
      r.val.units = v.units + 4'd1;
    end
    return r;
  endfunction

  function automatic logic bcd_valid_time(input bcd_pair_t h, input bcd_pair_t m,
                                          input bcd_pair_t s);
    return (h.units <= UNITS_MAX) && (m.units <= UNITS_MAX) && (s.units <= UNITS_MAX) &&
           (m.tens <= SEC_MAX_TENS) && (s.tens <= SEC_MAX_TENS) && ({1'b0, h} <= HR_MAX);
  endfunction

  // Returns {pm, hour} with hour in 12-hour BCD (00 presents as 12).
  function automatic logic [7:0] hr24_to_12(input bcd_pair_t h);
    logic [4:0] bin;
    logic [4:0] b12;
    logic       pm;
    bcd_pair_t  o;
    bin = ({2'b00, h.tens} * 5'd10) + {1'b0, h.units};
    pm  = (bin >= 5'd12);
    b12 = pm ? (bin - 5'd12) : bin;
    if (b12 == 5'd0) b12 = 5'd12;
    o.tens  = (b12 >= 5'd10) ? 3'd1 : 3'd0;
    o.units = (b12 >= 5'd10) ? 4'(b12 - 5'd10) : b12[3:0];
    return {pm, o};
  endfunction

endpackage

`default_nettype wire

// File: rtl/rtc_tick_sync.sv
// ============================================================================
// rtc_tick_sync : synchroniser and rising-edge detect for the one-second tick
// Revision: 1.0
// ============================================================================
`default_nettype none

module rtc_tick_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic NRST,
  input  logic sec_inc,
  output logic tick
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sec_inc};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign tick = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/rtc_bcd_counter.sv
// ============================================================================
// rtc_bcd_counter : 24-hour BCD time-of-day counter with load, 12/24h display,
//                   hh:mm alarm and day-rollover strobe
// Revision: 1.0
// ============================================================================
`default_nettype none

module rtc_bcd_counter
  import rtc_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit ALARM_EN    = 1'b1
) (
  input  logic       CLK,
  input  logic       NRST,
  input  logic       sec_inc,
  input  logic       mode_12h,
  input  logic       load,
  input  logic [6:0] ld_hr,
  input  logic [6:0] ld_min,
  input  logic [6:0] ld_sec,
  input  logic       alarm_on,
  input  logic [6:0] alarm_hr,
  input  logic [6:0] alarm_min,
  output logic [6:0] hr,
  output logic [6:0] min,
  output logic [6:0] sec,
  output logic       pm,
  output logic       day_carry,
  output logic       alarm,
  output logic       load_err
);

  logic      w_tick;
  bcd_pair_t r_h, r_m, r_s;
  bcd_pair_t w_h_nxt, w_m_nxt, w_s_nxt;
  bcd_inc_t  w_s_inc, w_m_inc;
  logic      w_day;
  logic      w_ld_ok;
  logic [7:0] w_h12;
  logic      r_day_pend;
  logic      r_err_pend;

  rtc_tick_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_tick_sync (
    .CLK    (CLK),
    .NRST   (NRST),
    .sec_inc(sec_inc),
    .tick   (w_tick)
  );

  // Whole carry chain resolves combinationally so no intermediate value is ever stored.
  always_comb begin
    w_s_inc = bcd_pair_inc(r_s, SEC_MAX_TENS);
    w_m_inc = bcd_pair_inc(r_m, SEC_MAX_TENS);
    w_day   = w_s_inc.carry & w_m_inc.carry & ({1'b0, r_h} == HR_MAX);
    w_s_nxt = w_s_inc.val;
    w_m_nxt = w_s_inc.carry ? w_m_inc.val : r_m;
    w_h_nxt = r_h;
    if (w_s_inc.carry & w_m_inc.carry) begin
      if (w_day) begin
        w_h_nxt = '0;
      end else if (r_h.units == UNITS_MAX) begin
        w_h_nxt.tens  = r_h.tens + 3'd1;
        w_h_nxt.units = 4'd0;
      end else begin
        w_h_nxt.units = r_h.units + 4'd1;
      end
    end
    w_ld_ok = bcd_valid_time(ld_hr, ld_min, ld_sec);
    w_h12   = hr24_to_12(r_h);
  end

  // A load always wins; a coincident tick is dropped rather than deferred.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_h        <= '0;
      r_m        <= '0;
      r_s        <= '0;
      r_day_pend <= 1'b0;
      r_err_pend <= 1'b0;
    end else begin
      r_day_pend <= 1'b0;
      r_err_pend <= 1'b0;
      if (load) begin
        if (w_ld_ok) begin
          r_h <= ld_hr;
          r_m <= ld_min;
          r_s <= ld_sec;
        end else begin
          r_err_pend <= 1'b1;
        end
      end else if (w_tick) begin
        r_h        <= w_h_nxt;
        r_m        <= w_m_nxt;
        r_s        <= w_s_nxt;
        r_day_pend <= w_day;
      end
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      hr        <= '0;
      min       <= '0;
      sec       <= '0;
      pm        <= 1'b0;
      day_carry <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      hr        <= mode_12h ? w_h12[6:0] : r_h;
      min       <= r_m;
      sec       <= r_s;
      pm        <= mode_12h & w_h12[7];
      day_carry <= r_day_pend;
      load_err  <= r_err_pend;
    end
  end

  generate
    if (ALARM_EN) begin : g_alarm
      logic r_alarm_pend;
      logic w_match;

      assign w_match = alarm_on && (w_h_nxt == alarm_hr) && (w_m_nxt == alarm_min) &&
                       (w_s_nxt == '0);

      always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
          r_alarm_pend <= 1'b0;
          alarm        <= 1'b0;
        end else begin
          r_alarm_pend <= w_tick & ~load & w_match;
          alarm        <= r_alarm_pend;
        end
      end
    end else begin : g_no_alarm
      assign alarm = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_rtc_bcd_counter.sv
// ============================================================================
// tb_rtc_bcd_counter : self-checking bench; reference time kept as seconds-of-day
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rtc_bcd_counter;

  logic       CLK = 1'b0;
  logic       NRST = 1'b1;
  logic       sec_inc = 1'b0;
  logic       mode_12h = 1'b0;
  logic       load = 1'b0;
  logic       alarm_on = 1'b0;
  logic [6:0] ld_hr = '0, ld_min = '0, ld_sec = '0;
  logic [6:0] alarm_hr = 7'h07, alarm_min = 7'h30;
  logic [6:0] hr, min, sec;
  logic       pm, day_carry, alarm, load_err;

  int n_vec = 0, n_err = 0;
  int n_alarm = 0, n_day = 0;
  int t_ref = 0;
  logic [21:0] got, exp_v;

  rtc_bcd_counter #(.SYNC_STAGES(2), .ALARM_EN(1'b1)) dut (
    .CLK(CLK), .NRST(NRST), .sec_inc(sec_inc), .mode_12h(mode_12h), .load(load),
    .ld_hr(ld_hr), .ld_min(ld_min), .ld_sec(ld_sec), .alarm_on(alarm_on),
    .alarm_hr(alarm_hr), .alarm_min(alarm_min), .hr(hr), .min(min), .sec(sec),
    .pm(pm), .day_carry(day_carry), .alarm(alarm), .load_err(load_err)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (alarm === 1'b1) n_alarm++;
    if (day_carry === 1'b1) n_day++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [6:0] bcd(input int v);
    logic [6:0] r;
    r[6:4] = 3'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  // Expected {hr, min, sec, pm} from a seconds-of-day value.
  function automatic logic [21:0] exp_disp(input int t, input logic m12);
    int h, dh;
    logic p;
    h = t / 3600;
    if (m12) begin
      dh = (h % 12 == 0) ? 12 : h % 12;
      p  = (h >= 12);
    end else begin
      dh = h;
      p  = 1'b0;
    end
    return {bcd(dh), bcd((t / 60) % 60), bcd(t % 60), p};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_tick();
    sec_inc = 1'b1;
    repeat (4) step();
    sec_inc = 1'b0;
    repeat (4) step();
    t_ref = (t_ref + 1) % 86400;
  endtask

  // Leaves the bench just after the edge where load_err becomes visible.
  task automatic do_load_raw(input logic [6:0] h, input logic [6:0] m, input logic [6:0] s);
    ld_hr = h; ld_min = m; ld_sec = s;
    load = 1'b1;
    step();
    load = 1'b0;
    step();
  endtask

  task automatic do_load(input int h, input int m, input int s);
    do_load_raw(bcd(h), bcd(m), bcd(s));
    t_ref = h * 3600 + m * 60 + s;
  endtask

  task automatic test_reset();
    #1 NRST = 1'b0;
    #1;
    n_vec++;
    if ({hr, min, sec, pm, day_carry, alarm, load_err} !== 25'd0) begin
      n_err++;
      $display("FAIL reset_async got=%h exp=0", {hr, min, sec, pm, day_carry, alarm, load_err});
    end
    mode_12h = 1'b1;
    repeat (2) step();
    NRST = 1'b1;
    step();
    t_ref = 0;
    got = {hr, min, sec, pm}; exp_v = exp_disp(t_ref, 1'b1); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL reset_12h got=%h exp=%h", got, exp_v); end
    mode_12h = 1'b0;
    step();
    got = {hr, min, sec, pm}; exp_v = exp_disp(t_ref, 1'b0); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL reset_24h got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_tick_latency();
    for (int i = 0; i < 3; i++) begin
      sec_inc = 1'b1;
      repeat (3) step();
      got = {hr, min, sec, pm}; exp_v = exp_disp(t_ref, mode_12h); n_vec++;
      if (got !== exp_v) begin n_err++; $display("FAIL tick_early got=%h exp=%h", got, exp_v); end
      step();
      t_ref = (t_ref + 1) % 86400;
      got = {hr, min, sec, pm}; exp_v = exp_disp(t_ref, mode_12h); n_vec++;
      if (got !== exp_v) begin n_err++; $display("FAIL tick_latency got=%h exp=%h", got, exp_v); end
      repeat (3) step();
      sec_inc = 1'b0;
      repeat (4) step();
    end
  endtask

  task automatic test_hold_high();
    sec_inc = 1'b1;
    repeat (20) step();
    sec_inc = 1'b0;
    repeat (5) step();
    t_ref = (t_ref + 1) % 86400;
    got = {hr, min, sec, pm}; exp_v = exp_disp(t_ref, mode_12h); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL hold_high got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_rollover();
    int d0;
    do_load(23, 59, 58);
    d0 = n_day;
    do_tick();
    got = {hr, min, sec, pm}; exp_v = exp_disp(t_ref, mode_12h); n_vec++;
    if (got !== exp_v || n_day != d0) begin
      n_err++; $display("FAIL pre_rollover got=%h/%0d exp=%h/%0d", got, n_day, exp_v, d0);
    end
    sec_inc = 1'b1;
    repeat (4) step();
    t_ref = 0;
    got = {hr, min, sec, pm}; exp_v = exp_disp(t_ref, mode_12h); n_vec++;
    if ({got, day_carry} !== {exp_v, 1'b1}) begin
      n_err++; $display("FAIL day_rollover got=%h dc=%b exp=%h dc=1", got, day_carry, exp_v);
    end
    step();
    n_vec++;
    if (day_carry !== 1'b0) begin n_err++; $display("FAIL day_carry_width got=%b exp=0", day_carry); end
    sec_inc = 1'b0;
    repeat (4) step();
    n_vec++;
    if (n_day != d0 + 1) begin n_err++; $display("FAIL day_carry_count got=%0d exp=%0d", n_day, d0 + 1); end
    do_load(9, 59, 59);
    do_tick();
    got = {hr, min, sec, pm}; exp_v = exp_disp(t_ref, mode_12h); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL hr_09_10 got=%h exp=%h", got, exp_v); end
    do_load(19, 59, 59);
    do_tick();
    got = {hr, min, sec, pm}; exp_v = exp_disp(t_ref, mode_12h); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL hr_19_20 got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_load_err();
    logic [20:0] bad [3];
    bad[0] = {7'h10, 7'h60, 7'h00};
    bad[1] = {7'h24, 7'h00, 7'h00};
    bad[2] = {7'h10, 7'h20, 7'h0A};
    do_load(10, 20, 30);
    n_vec++;
    if (load_err !== 1'b0) begin n_err++; $display("FAIL load_ok_err got=%b exp=0", load_err); end
    for (int i = 0; i < 3; i++) begin
      do_load_raw(bad[i][20:14], bad[i][13:7], bad[i][6:0]);
      n_vec++;
      if (load_err !== 1'b1) begin n_err++; $display("FAIL load_err_%0d got=%b exp=1", i, load_err); end
      step();
      got = {hr, min, sec, pm}; exp_v = exp_disp(t_ref, mode_12h); n_vec++;
      if ({got, load_err} !== {exp_v, 1'b0}) begin
        n_err++; $display("FAIL load_err_keep_%0d got=%h/%b exp=%h/0", i, got, load_err, exp_v);
      end
    end
  endtask

  task automatic test_load_tick_collision();
    sec_inc = 1'b1;
    repeat (2) step();
    ld_hr = 7'h12; ld_min = 7'h00; ld_sec = 7'h00;
    load = 1'b1;
    step();
    load = 1'b0;
    repeat (2) step();
    sec_inc = 1'b0;
    repeat (4) step();
    t_ref = 12 * 3600;
    got = {hr, min, sec, pm}; exp_v = exp_disp(t_ref, mode_12h); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL load_tick_collision got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_12h();
    int hrs [4];
    hrs[0] = 0; hrs[1] = 12; hrs[2] = 13; hrs[3] = 23;
    mode_12h = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_load(hrs[i], 34, 56);
      got = {hr, min, sec, pm}; exp_v = exp_disp(t_ref, 1'b1); n_vec++;
      if (got !== exp_v) begin n_err++; $display("FAIL map12_h%0d got=%h exp=%h", hrs[i], got, exp_v); end
    end
    mode_12h = 1'b0;
    step();
    got = {hr, min, sec, pm}; exp_v = exp_disp(t_ref, 1'b0); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL mode_toggle24 got=%h exp=%h", got, exp_v); end
    mode_12h = 1'b1;
    do_load(11, 59, 59);
    do_tick();
    got = {hr, min, sec, pm}; exp_v = exp_disp(t_ref, 1'b1); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL map12_noon_tick got=%h exp=%h", got, exp_v); end
    mode_12h = 1'b0;
    step();
  endtask

  task automatic test_alarm();
    int a0;
    alarm_on = 1'b1;
    do_load(7, 29, 59);
    a0 = n_alarm;
    sec_inc = 1'b1;
    repeat (4) step();
    n_vec++;
    if ({alarm, min} !== {1'b1, 7'h30}) begin
      n_err++; $display("FAIL alarm_fire got=%b/%h exp=1/30", alarm, min);
    end
    step();
    n_vec++;
    if (alarm !== 1'b0) begin n_err++; $display("FAIL alarm_width got=%b exp=0", alarm); end
    sec_inc = 1'b0;
    repeat (4) step();
    t_ref = 7 * 3600 + 30 * 60;
    n_vec++;
    if (n_alarm != a0 + 1) begin n_err++; $display("FAIL alarm_count got=%0d exp=%0d", n_alarm, a0 + 1); end
    a0 = n_alarm;
    do_load(7, 30, 0);
    repeat (3) step();
    n_vec++;
    if (n_alarm != a0) begin n_err++; $display("FAIL alarm_on_load got=%0d exp=%0d", n_alarm, a0); end
    alarm_on = 1'b0;
    do_load(7, 29, 59);
    do_tick();
    got = {hr, min, sec, pm}; exp_v = exp_disp(t_ref, mode_12h); n_vec++;
    if (n_alarm != a0 || got !== exp_v) begin
      n_err++; $display("FAIL alarm_off got=%0d/%h exp=%0d/%h", n_alarm, got, a0, exp_v);
    end
  endtask

  task automatic test_random();
    int op, r;
    logic [6:0] bh, bm, bs;
    alarm_on = 1'b0;
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 3));
      case (op)
        0: begin
          r = int'($urandom_range(0, 86399));
          do_load(r / 3600, (r / 60) % 60, r % 60);
          n_vec++;
          if (load_err !== 1'b0) begin n_err++; $display("FAIL rnd_load_ok_%0d got=%b exp=0", i, load_err); end
        end
        1: begin
          r  = int'($urandom_range(0, 86399));
          bh = bcd(r / 3600); bm = bcd((r / 60) % 60); bs = bcd(r % 60);
          case ($urandom_range(0, 2))
            0: bm = {3'($urandom_range(6, 7)), 4'($urandom_range(0, 9))};
            1: bh = {3'd2, 4'($urandom_range(4, 9))};
            default: bs = {3'($urandom_range(0, 5)), 4'($urandom_range(10, 15))};
          endcase
          do_load_raw(bh, bm, bs);
          n_vec++;
          if (load_err !== 1'b1) begin n_err++; $display("FAIL rnd_load_bad_%0d got=%b exp=1", i, load_err); end
        end
        2: do_tick();
        default: begin
          mode_12h = ~mode_12h;
          step();
        end
      endcase
      got = {hr, min, sec, pm}; exp_v = exp_disp(t_ref, mode_12h); n_vec++;
      if (got !== exp_v) begin n_err++; $display("FAIL rnd_%0d op%0d got=%h exp=%h", i, op, got, exp_v); end
    end
    mode_12h = 1'b0;
    step();
  endtask

  task automatic test_reset_inflight();
    do_load(5, 6, 7);
    sec_inc = 1'b1;
    step();
    NRST = 1'b0;
    #1;
    n_vec++;
    if ({hr, min, sec, pm, day_carry, alarm, load_err} !== 25'd0) begin
      n_err++; $display("FAIL reset_inflight_async got=%h exp=0", {hr, min, sec, pm, day_carry, alarm, load_err});
    end
    sec_inc = 1'b0;
    repeat (2) step();
    NRST = 1'b1;
    repeat (6) step();
    t_ref = 0;
    got = {hr, min, sec, pm}; exp_v = exp_disp(t_ref, mode_12h); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL reset_inflight_noinc got=%h exp=%h", got, exp_v); end
  endtask

  initial begin
    test_reset();
    test_tick_latency();
    test_hold_high();
    test_rollover();
    test_load_err();
    test_load_tick_collision();
    test_12h();
    test_alarm();
    test_random();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
